// File: rtl/mips_pkg.sv
// Shared definitions for the ID/EX pipeline slice: FSM encoding, field widths, bubble value.
package mips_pkg;

  localparam int N       = 5;
  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 3;
  localparam int CNT_W   = 16;

  // Hazard FSM encoding
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FROZEN   = 2'd2
  } state_t;

  // Control bundle: RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp
  localparam int CTRL_W = 6 + ALUOP_W;

  // A bubble is an instruction whose control fields are all zero (no side effects)
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use compare between the load in EX and the sources of the instruction in ID.
module load_use_detector #(
  parameter int N = mips_pkg::N
) (
  input  logic         i_ex_memread,
  input  logic [N-1:0] i_ex_rt,
  input  logic [N-1:0] i_id_rs,
  input  logic [N-1:0] i_id_rt,
  output logic         o_lu
);

  logic w_rt_nonzero;
  logic w_src_match;

  // $0 is hard-wired, so a load targeting it never creates a dependency
  assign w_rt_nonzero = (i_ex_rt != '0);
  assign w_src_match  = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);
  assign o_lu         = i_ex_memread & w_rt_nonzero & w_src_match;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, global hold and stall counting.
module id_ex_hazard_stage #(
  parameter int N       = mips_pkg::N,
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int ALUOP_W = mips_pkg::ALUOP_W,
  parameter int CNT_W   = mips_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic               flush,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemtoReg,
  input  logic               ID_ALUSrc,
  input  logic               ID_RegDst,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [N-1:0]       ID_Rs,
  input  logic [N-1:0]       ID_Rt,
  input  logic [N-1:0]       ID_Rd,
  output logic               EX_RegWrite,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic               EX_MemtoReg,
  output logic               EX_ALUSrc,
  output logic               EX_RegDst,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic [DATA_W-1:0]  EX_ReadData1,
  output logic [DATA_W-1:0]  EX_ReadData2,
  output logic [DATA_W-1:0]  EX_Imm,
  output logic [N-1:0]       EX_Rs,
  output logic [N-1:0]       EX_Rt,
  output logic [N-1:0]       EX_Rd,
  output logic               pc_write,
  output logic               ifid_write,
  output logic [CNT_W-1:0]   stall_count
);

  import mips_pkg::*;

  localparam int CW = 6 + ALUOP_W;
  localparam logic [CW-1:0] BUBBLE = CW'(CTRL_BUBBLE);

  logic [CW-1:0]     w_id_ctrl;
  logic [CW-1:0]     r_ex_ctrl;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [N-1:0]      r_rs;
  logic [N-1:0]      r_rt;
  logic [N-1:0]      r_rd;
  logic [CNT_W-1:0]  r_stall_cnt;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_lu;
  logic              w_bubble;
  logic              w_lu_stall;

  // Saturating increment: the counter sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign w_id_ctrl = {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg,
                      ID_ALUSrc, ID_RegDst, ID_ALUOp};

  assign {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg,
          EX_ALUSrc, EX_RegDst, EX_ALUOp} = r_ex_ctrl;
  assign EX_ReadData1 = r_rd1;
  assign EX_ReadData2 = r_rd2;
  assign EX_Imm       = r_imm;
  assign EX_Rs        = r_rs;
  assign EX_Rt        = r_rt;
  assign EX_Rd        = r_rd;
  assign stall_count  = r_stall_cnt;

  load_use_detector #(.N(N)) u_lu (
    .i_ex_memread (EX_MemRead),
    .i_ex_rt      (r_rt),
    .i_id_rs      (ID_Rs),
    .i_id_rt      (ID_Rt),
    .o_lu         (w_lu)
  );

  // A flushed ID instruction is discarded, so a hazard against it needs no stall
  assign w_lu_stall = w_lu & ~hold & ~flush;
  assign w_bubble   = flush | w_lu;
  assign pc_write   = ~hold & ~w_lu_stall;
  assign ifid_write = ~hold & ~w_lu_stall;

  // Next-state logic: hold dominates; otherwise a stall lasts exactly one cycle
  always_comb begin
    w_state_nxt = RUN;
    if (hold) begin
      w_state_nxt = FROZEN;
    end else begin
      case (r_state)
        RUN, FROZEN: w_state_nxt = w_lu_stall ? LU_STALL : RUN;
        LU_STALL:    w_state_nxt = RUN;
        default:     w_state_nxt = RUN;
      endcase
    end
  end

  // FSM state register and stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lu_stall) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
    end
  end

  // ID/EX register bank: hold freezes everything, a bubble zeroes only the control fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_ctrl <= BUBBLE;
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
    end else if (!hold) begin
      r_ex_ctrl <= w_bubble ? BUBBLE : w_id_ctrl;
      r_rd1     <= ID_ReadData1;
      r_rd2     <= ID_ReadData2;
      r_imm     <= ID_Imm;
      r_rs      <= ID_Rs;
      r_rt      <= ID_Rt;
      r_rd      <= ID_Rd;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage: behavioural model plus directed hazard scenarios.
module tb_id_ex_hazard_stage;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          hold;
  logic          flush;
  logic          ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst;
  logic [AW-1:0] ID_ALUOp;
  logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_Imm;
  logic [N-1:0]  ID_Rs, ID_Rt, ID_Rd;
  logic          EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst;
  logic [AW-1:0] EX_ALUOp;
  logic [DW-1:0] EX_ReadData1, EX_ReadData2, EX_Imm;
  logic [N-1:0]  EX_Rs, EX_Rt, EX_Rd;
  logic          pc_write, ifid_write;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  id_ex_hazard_stage #(.N(N), .DATA_W(DW), .ALUOP_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
    .ID_ALUOp(ID_ALUOp), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemtoReg(EX_MemtoReg), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
    .EX_ALUOp(EX_ALUOp), .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_Imm(EX_Imm), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .pc_write(pc_write), .ifid_write(ifid_write), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected contents of the EX stage as an instruction record
  typedef struct {
    logic          rw, mr, mw, m2r, as, rdst;
    logic [AW-1:0] op;
    logic [DW-1:0] d1, d2, imm;
    logic [N-1:0]  rs, rt, rd;
  } ex_t;

  ex_t m;
  int  mcnt;

  // True when the instruction in ID reads the register the EX-stage load writes
  function automatic bit m_lu();
    return m.mr && (m.rt != 0) && (m.rt == ID_Rs || m.rt == ID_Rt);
  endfunction

  // Model: what EX must hold after each edge, from the stage's priority rules
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m    <= '{default: '0};
      mcnt <= 0;
    end else if (!hold) begin
      if (flush || m_lu()) begin
        m.rw <= 0; m.mr <= 0; m.mw <= 0; m.m2r <= 0; m.as <= 0; m.rdst <= 0; m.op <= '0;
      end else begin
        m.rw <= ID_RegWrite; m.mr <= ID_MemRead; m.mw <= ID_MemWrite;
        m.m2r <= ID_MemtoReg; m.as <= ID_ALUSrc; m.rdst <= ID_RegDst; m.op <= ID_ALUOp;
      end
      m.d1 <= ID_ReadData1; m.d2 <= ID_ReadData2; m.imm <= ID_Imm;
      m.rs <= ID_Rs; m.rt <= ID_Rt; m.rd <= ID_Rd;
      if (!flush && m_lu() && mcnt < (2**CW - 1)) mcnt <= mcnt + 1;
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    chk("EX_RegWrite", EX_RegWrite, m.rw);
    chk("EX_MemRead", EX_MemRead, m.mr);
    chk("EX_MemWrite", EX_MemWrite, m.mw);
    chk("EX_MemtoReg", EX_MemtoReg, m.m2r);
    chk("EX_ALUSrc", EX_ALUSrc, m.as);
    chk("EX_RegDst", EX_RegDst, m.rdst);
    chk("EX_ALUOp", EX_ALUOp, m.op);
    chk("EX_ReadData1", EX_ReadData1, m.d1);
    chk("EX_ReadData2", EX_ReadData2, m.d2);
    chk("EX_Imm", EX_Imm, m.imm);
    chk("EX_Rs", EX_Rs, m.rs);
    chk("EX_Rt", EX_Rt, m.rt);
    chk("EX_Rd", EX_Rd, m.rd);
    chk("pc_write", pc_write, !(hold || (m_lu() && !flush)));
    chk("ifid_write", ifid_write, !(hold || (m_lu() && !flush)));
    chk("stall_count", stall_count, mcnt);
  end

  task automatic clr_id();
    ID_RegWrite = 0; ID_MemRead = 0; ID_MemWrite = 0; ID_MemtoReg = 0;
    ID_ALUSrc = 0; ID_RegDst = 0; ID_ALUOp = '0;
    ID_ReadData1 = '0; ID_ReadData2 = '0; ID_Imm = '0;
    ID_Rs = '0; ID_Rt = '0; ID_Rd = '0;
  endtask

  task automatic set_lw(input logic [N-1:0] rs, input logic [N-1:0] rt);
    clr_id();
    ID_RegWrite = 1; ID_MemRead = 1; ID_MemtoReg = 1; ID_ALUSrc = 1;
    ID_Rs = rs; ID_Rt = rt; ID_ReadData1 = $urandom; ID_Imm = $urandom;
  endtask

  task automatic set_add(input logic [N-1:0] rs, input logic [N-1:0] rt, input logic [N-1:0] rd);
    clr_id();
    ID_RegWrite = 1; ID_RegDst = 1; ID_ALUOp = 3'd2;
    ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
    ID_ReadData1 = $urandom; ID_ReadData2 = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0; hold = 0; flush = 0;
    clr_id();
    tick(); tick();
    chk("rst EX_RegWrite", EX_RegWrite, 0);
    chk("rst stall_count", stall_count, 0);
    chk("rst pc_write", pc_write, 1);
    chk("rst state", dut.r_state, 0);
    reset = 1;
    tick();

    // lw $8 then add $9,$8,$10: one-cycle stall
    set_lw(5'd1, 5'd8);
    tick();
    set_add(5'd8, 5'd10, 5'd9);
    #1;
    chk("lu pc_write", pc_write, 0);
    chk("lu ifid_write", ifid_write, 0);
    tick();
    chk("lu bubble RegWrite", EX_RegWrite, 0);
    chk("lu bubble MemRead", EX_MemRead, 0);
    chk("lu stall_count", stall_count, 1);
    chk("lu state", dut.r_state, 1);
    chk("lu released pc_write", pc_write, 1);
    tick();
    chk("lu add RegWrite", EX_RegWrite, 1);
    chk("lu add Rd", EX_Rd, 9);
    chk("lu add Rs", EX_Rs, 8);

    // Load to $0 never stalls
    set_lw(5'd2, 5'd0);
    tick();
    set_add(5'd0, 5'd3, 5'd4);
    #1;
    chk("r0 pc_write", pc_write, 1);
    tick();
    chk("r0 add RegWrite", EX_RegWrite, 1);
    chk("r0 add Rd", EX_Rd, 4);
    chk("r0 stall_count", stall_count, 1);

    // Load-use coinciding with flush: bubble but no stall
    set_lw(5'd1, 5'd8);
    tick();
    set_add(5'd8, 5'd8, 5'd5);
    flush = 1;
    #1;
    chk("flush pc_write", pc_write, 1);
    tick();
    flush = 0;
    clr_id();
    chk("flush RegWrite", EX_RegWrite, 0);
    chk("flush Rs", EX_Rs, 8);
    chk("flush stall_count", stall_count, 1);
    chk("flush state", dut.r_state, 0);
    tick();

    // Hold for three cycles while a stall bubble sits in EX
    set_lw(5'd1, 5'd7);
    tick();
    set_add(5'd3, 5'd7, 5'd6);
    tick();
    chk("hold pre stall_count", stall_count, 2);
    hold = 1;
    repeat (3) begin
      tick();
      chk("hold pc_write", pc_write, 0);
      chk("hold MemRead", EX_MemRead, 0);
      chk("hold state", dut.r_state, 2);
    end
    hold = 0;
    #1;
    chk("hold release pc_write", pc_write, 1);
    tick();
    chk("hold add RegWrite", EX_RegWrite, 1);
    chk("hold add Rd", EX_Rd, 6);
    chk("hold stall_count", stall_count, 2);

    // Reset asserted with a stall pending and RegWrite=1 in EX
    set_lw(5'd1, 5'd8);
    tick();
    set_add(5'd8, 5'd0, 5'd9);
    #1;
    chk("mid pc_write pre", pc_write, 0);
    reset = 0;
    #1;
    chk("mid rst RegWrite", EX_RegWrite, 0);
    chk("mid rst MemRead", EX_MemRead, 0);
    chk("mid rst stall_count", stall_count, 0);
    chk("mid rst state", dut.r_state, 0);
    chk("mid rst pc_write", pc_write, 1);
    reset = 1;
    tick();

    // Saturation: 2^CW+2 stalls
    repeat ((2**CW) + 2) begin
      set_lw(5'd1, 5'd8);
      tick();
      set_add(5'd8, 5'd2, 5'd3);
      tick();
      tick();
    end
    chk("sat stall_count", stall_count, 4'hF);

    // Mixed traffic on a small register set, checked by the model
    repeat (60) begin
      if ($urandom_range(0, 1) == 0) set_lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      else set_add(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      tick();
    end
    hold = 0; flush = 0;
    clr_id();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
